// File: rtl/fpmul_pkg.sv
// Shared types and constants for the single-precision multiplier result stage.
// Flag bit positions follow the {exception, overflow, underflow} packing used on out_flags.
package fpmul_pkg;

  localparam int unsigned FP_W     = 32;
  localparam int unsigned FLAG_W   = 3;
  localparam int unsigned FLAG_EXC = 2;
  localparam int unsigned FLAG_OVF = 1;
  localparam int unsigned FLAG_UDF = 0;

  localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP_POS_INF  = 32'h7F80_0000;

  typedef struct packed {
    logic [FLAG_W-1:0] flags;
    logic [FP_W-1:0]   result;
  } fpmul_entry_t;

  function automatic logic entry_flagged(input fpmul_entry_t e);
    return |e.flags;
  endfunction

endpackage

// File: rtl/fpmul_result_buffer_if.sv
// Producer/consumer handshake bundle around the multiplier result buffer.
// The buffer uses the slave view; the multiplier/consumer side uses the master view.
interface fpmul_result_buffer_if;
  import fpmul_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [FP_W-1:0]     in_result;
  logic                in_exception;
  logic                in_overflow;
  logic                in_underflow;
  logic                out_valid;
  logic                out_ready;
  logic [FP_W-1:0]     out_result;
  logic [FLAG_W-1:0]   out_flags;

  modport slave (
    input  in_valid, in_result, in_exception, in_overflow, in_underflow, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );

  modport master (
    output in_valid, in_result, in_exception, in_overflow, in_underflow, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

endinterface

// File: rtl/fpmul_sync_fifo.sv
// Generic single-clock FIFO with wrap-bit pointers and synchronous flush.
// When empty, rdata holds the last popped word so the output never shows stale slots or X.
module fpmul_sync_fifo #(
  parameter int unsigned WIDTH = 35,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = (AW+1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] last_q;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A push coinciding with flush is dropped rather than landing in an emptied FIFO.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_pop) last_q <= mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = empty ? last_q : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/fpmul_result_buffer.sv
// Result buffer behind the combinational FP multiplier: FIFO plus sticky IEEE flags
// and saturating accepted/flagged result counters.
module fpmul_result_buffer
  import fpmul_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  fpmul_result_buffer_if.slave bus,
  input  logic                flush,
  input  logic                clear_sticky,
  output logic [FLAG_W-1:0]   sticky_flags,
  output logic [CNT_W-1:0]    count_total,
  output logic [CNT_W-1:0]    count_flagged
);

  localparam int unsigned EntryW = $bits(fpmul_entry_t);
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  fpmul_entry_t       in_entry, out_entry;
  logic [EntryW-1:0]  fifo_rdata;
  logic               fifo_full, fifo_empty;
  logic               push, pop;

  logic [FLAG_W-1:0]  sticky_q, sticky_d;
  logic [CNT_W-1:0]   total_q, total_d;
  logic [CNT_W-1:0]   flagged_q, flagged_d;

  always_comb begin
    in_entry                 = '0;
    in_entry.result          = bus.in_result;
    in_entry.flags[FLAG_EXC] = bus.in_exception;
    in_entry.flags[FLAG_OVF] = bus.in_overflow;
    in_entry.flags[FLAG_UDF] = bus.in_underflow;
  end

  assign bus.in_ready  = ~fifo_full;
  assign bus.out_valid = ~fifo_empty;
  assign push          = bus.in_valid & ~fifo_full & ~flush;
  assign pop           = ~fifo_empty & bus.out_ready;

  fpmul_sync_fifo #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (in_entry),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_entry      = fpmul_entry_t'(fifo_rdata);
  assign bus.out_result = out_entry.result;
  assign bus.out_flags  = out_entry.flags;

  always_comb begin
    sticky_d  = sticky_q;
    total_d   = total_q;
    flagged_d = flagged_q;
    // Flags set by a push in the same cycle as clear survive the clear.
    if (clear_sticky) sticky_d = '0;
    if (push) begin
      sticky_d = sticky_d | in_entry.flags;
      if (total_q != CntMax) total_d = total_q + CntOne;
      if (entry_flagged(in_entry) && (flagged_q != CntMax)) flagged_d = flagged_q + CntOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q  <= '0;
      total_q   <= '0;
      flagged_q <= '0;
    end else begin
      sticky_q  <= sticky_d;
      total_q   <= total_d;
      flagged_q <= flagged_d;
    end
  end

  assign sticky_flags  = sticky_q;
  assign count_total   = total_q;
  assign count_flagged = flagged_q;

endmodule

// File: tb/tb_fpmul_result_buffer.sv
// Directed bench for fpmul_result_buffer: cycle-by-cycle vector table plus wrap,
// flush, async-reset and counter-saturation sequences.
module tb_fpmul_result_buffer;

  logic clk;
  logic rst_n;
  logic flush, clear_sticky;
  logic [2:0]  sticky_flags;
  logic [15:0] count_total, count_flagged;

  logic sat_flush, sat_clear;
  logic [2:0] sat_sticky;
  logic [1:0] sat_total, sat_flagged;

  int n_tests = 0;
  int n_fail  = 0;

  fpmul_result_buffer_if bus ();
  fpmul_result_buffer_if sat_bus ();

  fpmul_result_buffer #(.DEPTH(4), .CNT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .flush         (flush),
    .clear_sticky  (clear_sticky),
    .sticky_flags  (sticky_flags),
    .count_total   (count_total),
    .count_flagged (count_flagged)
  );

  fpmul_result_buffer #(.DEPTH(4), .CNT_W(2)) u_sat (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (sat_bus),
    .flush         (sat_flush),
    .clear_sticky  (sat_clear),
    .sticky_flags  (sat_sticky),
    .count_total   (sat_total),
    .count_flagged (sat_flagged)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vin;
    logic [31:0] res;
    logic [2:0]  fl;
    logic        ordy;
    logic        clr;
    logic        e_ov;
    logic        e_ir;
    logic [31:0] e_res;
    logic [2:0]  e_fl;
    logic [2:0]  e_st;
    logic [15:0] e_tot;
    logic [15:0] e_flg;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vin, input logic [31:0] res, input logic [2:0] fl,
                       input logic ordy);
    bus.in_valid     = vin;
    bus.in_result    = res;
    bus.in_exception = fl[2];
    bus.in_overflow  = fl[1];
    bus.in_underflow = fl[0];
    bus.out_ready    = ordy;
  endtask

  function automatic logic [31:0] dval(input int j);
    return 32'h3F80_0000 + 32'(j);
  endfunction

  initial begin
    // vin, res, fl, ordy, clr | out_valid, in_ready, out_result, out_flags, sticky, total, flagged
    vecs[0]  = '{1'b1, 32'h43C8_0000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h43C8_0000, 3'b000, 3'b000, 16'd1, 16'd0};
    vecs[1]  = '{1'b0, 32'h0000_0000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h43C8_0000, 3'b000, 3'b000, 16'd1, 16'd0};
    vecs[2]  = '{1'b1, 32'h41A0_0000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h41A0_0000, 3'b000, 3'b000, 16'd2, 16'd0};
    vecs[3]  = '{1'b1, 32'h4532_10E9, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h41A0_0000, 3'b000, 3'b000, 16'd3, 16'd0};
    vecs[4]  = '{1'b1, 32'hC235_5062, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h41A0_0000, 3'b000, 3'b000, 16'd4, 16'd0};
    vecs[5]  = '{1'b1, 32'h441E_5375, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h41A0_0000, 3'b000, 3'b000, 16'd5, 16'd0};
    vecs[6]  = '{1'b1, 32'h3F80_0000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h41A0_0000, 3'b000, 3'b000, 16'd5, 16'd0};
    vecs[7]  = '{1'b1, 32'h3F80_0000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h4532_10E9, 3'b000, 3'b000, 16'd5, 16'd0};
    vecs[8]  = '{1'b0, 32'h0000_0000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 32'hC235_5062, 3'b000, 3'b000, 16'd5, 16'd0};
    vecs[9]  = '{1'b0, 32'h0000_0000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h441E_5375, 3'b000, 3'b000, 16'd5, 16'd0};
    vecs[10] = '{1'b0, 32'h0000_0000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h441E_5375, 3'b000, 3'b000, 16'd5, 16'd0};
    vecs[11] = '{1'b1, 32'h0000_0000, 3'b110, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 3'b110, 3'b110, 16'd6, 16'd1};
    vecs[12] = '{1'b1, 32'h0000_0000, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 3'b110, 3'b111, 16'd7, 16'd2};
    vecs[13] = '{1'b1, 32'h0000_0000, 3'b001, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 3'b110, 3'b001, 16'd8, 16'd3};
    vecs[14] = '{1'b0, 32'h0000_0000, 3'b000, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 3'b001, 3'b000, 16'd8, 16'd3};
    vecs[15] = '{1'b0, 32'h0000_0000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 3'b001, 3'b000, 16'd8, 16'd3};
    vecs[16] = '{1'b0, 32'h0000_0000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 3'b001, 3'b000, 16'd8, 16'd3};

    rst_n = 1'b1;
    flush = 1'b0;
    clear_sticky = 1'b0;
    sat_flush = 1'b0;
    sat_clear = 1'b0;
    sat_bus.in_valid = 1'b0;
    sat_bus.in_result = 32'h0;
    sat_bus.in_exception = 1'b0;
    sat_bus.in_overflow = 1'b0;
    sat_bus.in_underflow = 1'b0;
    sat_bus.out_ready = 1'b1;
    drive(1'b0, 32'h0, 3'b000, 1'b1);
    #2 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    tick();

    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_result", bus.out_result, 32'h0);
    check("reset_out_flags", 32'(bus.out_flags), 32'd0);
    check("reset_sticky", 32'(sticky_flags), 32'd0);
    check("reset_count_total", 32'(count_total), 32'd0);
    check("reset_count_flagged", 32'(count_flagged), 32'd0);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].vin, vecs[i].res, vecs[i].fl, vecs[i].ordy);
      clear_sticky = vecs[i].clr;
      tick();
      check($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
      check($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_ir));
      check($sformatf("vec%0d_out_result", i), bus.out_result, vecs[i].e_res);
      check($sformatf("vec%0d_out_flags", i), 32'(bus.out_flags), 32'(vecs[i].e_fl));
      check($sformatf("vec%0d_sticky", i), 32'(sticky_flags), 32'(vecs[i].e_st));
      check($sformatf("vec%0d_count_total", i), 32'(count_total), 32'(vecs[i].e_tot));
      check($sformatf("vec%0d_count_flagged", i), 32'(count_flagged), 32'(vecs[i].e_flg));
    end
    clear_sticky = 1'b0;

    // Steady push+pop at occupancy 2 across several pointer wraps.
    drive(1'b1, dval(0), 3'b000, 1'b0);
    tick();
    drive(1'b1, dval(1), 3'b000, 1'b0);
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, dval(k + 2), 3'b000, 1'b1);
      tick();
      check($sformatf("wrap%0d_head", k), bus.out_result, dval(k + 1));
      check($sformatf("wrap%0d_valid_ready", k), 32'({bus.out_valid, bus.in_ready}), 32'd3);
    end
    drive(1'b0, 32'h0, 3'b000, 1'b1);
    tick();
    check("wrap_drain_head", bus.out_result, dval(11));
    check("wrap_drain_valid", 32'(bus.out_valid), 32'd1);
    tick();
    check("wrap_drain_empty", 32'(bus.out_valid), 32'd0);
    check("wrap_count_total", 32'(count_total), 32'd20);

    // Flush with a simultaneous push: push is dropped and not counted.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h4049_0FDB + 32'(k), 3'b000, 1'b0);
      tick();
    end
    check("preflush_count_total", 32'(count_total), 32'd23);
    drive(1'b1, 32'hDEAD_BEEF, 3'b000, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    check("flush_count_total", 32'(count_total), 32'd23);
    drive(1'b1, 32'h1234_5678, 3'b000, 1'b0);
    tick();
    check("postflush_head", bus.out_result, 32'h1234_5678);
    check("postflush_valid", 32'(bus.out_valid), 32'd1);
    check("postflush_count_total", 32'(count_total), 32'd24);

    // Asynchronous reset mid-stream, asserted between clock edges.
    drive(1'b1, 32'h7F80_0000, 3'b010, 1'b0);
    tick();
    drive(1'b1, 32'h7F80_0000, 3'b100, 1'b0);
    tick();
    check("prereset_sticky", 32'(sticky_flags), 32'h6);
    drive(1'b0, 32'h0, 3'b000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("areset_out_valid", 32'(bus.out_valid), 32'd0);
    check("areset_out_result", bus.out_result, 32'h0);
    check("areset_out_flags", 32'(bus.out_flags), 32'd0);
    check("areset_sticky", 32'(sticky_flags), 32'd0);
    check("areset_count_total", 32'(count_total), 32'd0);
    check("areset_count_flagged", 32'(count_flagged), 32'd0);
    #10 rst_n = 1'b1;
    tick();
    check("postreset_in_ready", 32'(bus.in_ready), 32'd1);
    check("postreset_out_valid", 32'(bus.out_valid), 32'd0);

    // Narrow-counter instance: counters stop at all-ones.
    sat_bus.in_valid = 1'b1;
    sat_bus.in_exception = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sat_bus.in_result = 32'h4000_0000 + 32'(k);
      tick();
      check($sformatf("sat%0d_count_total", k), 32'(sat_total), (k < 3) ? 32'(k + 1) : 32'd3);
      check($sformatf("sat%0d_count_flagged", k), 32'(sat_flagged), (k < 3) ? 32'(k + 1) : 32'd3);
    end
    sat_bus.in_valid = 1'b0;
    check("sat_sticky", 32'(sat_sticky), 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
